layer46_train_sequencer: RTL and testbench

//  Sequences one training/inference sample through a 46-wide neuron_learn layer.
//  - Accepts an input vector and a class label over a valid/ready handshake.
//  - Drives the layer's in/valid, waits for its outputs to settle, then scans them for the argmax.
//  - In train mode, builds the one-hot-derived expected_out vector and pulses learn.
//  - Reports the predicted class and keeps accuracy counters.

---
 rtl/layer46_train_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_layer46_train_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer46_train_sequencer.sv
// Sequences one sample through a 46-neuron learning layer: hands the sample to
// the layer, waits for its outputs to settle, snapshots and scans them for the
// argmax, builds the blended expected_out vector, optionally pulses learn, then
// reports the predicted class and keeps saturating accuracy counters.
module layer46_train_sequencer #(
  parameter int N          = 16,
  parameter int M          = 46,
  parameter int SETTLE_CYC = 4,
  parameter int RATE_SHIFT = 2,
  parameter int CW         = 16,
  parameter int DW         = 8,
  parameter int LW         = $clog2(M)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N*DW-1:0]   s_in,
  input  logic [LW-1:0]     s_label,
  input  logic              s_train,
  output logic [N*DW-1:0]   l_in,
  output logic              l_valid,
  output logic              l_learn,
  input  logic [M*DW-1:0]   l_out,
  output logic [M*DW-1:0]   l_expected_out,
  output logic              r_valid,
  output logic [LW-1:0]     r_class,
  output logic              r_correct,
  input  logic              clear_stats,
  output logic [CW-1:0]     sample_count,
  output logic [CW-1:0]     correct_count
);

  localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETTLE, SCAN, LEARN, REPORT} state_t;

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]          idx_q, idx_d;
  logic [LW-1:0]          label_q, label_d;
  logic                   train_q, train_d;
  logic [LW-1:0]          best_idx_q, best_idx_d;
  logic [DW-1:0]          best_val_q, best_val_d;
  logic [LW-1:0]          r_class_q, r_class_d;
  logic                   r_correct_q, r_correct_d;
  logic [N*DW-1:0]        l_in_q, l_in_d;
  logic [M-1:0][DW-1:0]   snap_q, snap_d;
  logic [M-1:0][DW-1:0]   exp_q, exp_d;
  logic [CW-1:0]          sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]          correct_cnt_q, correct_cnt_d;

  logic [DW-1:0]          cur_val;
  logic [DW-1:0]          target;
  logic signed [DW:0]     diff;
  logic signed [DW:0]     blend_step;
  logic signed [DW+1:0]   blend_sum;
  logic [DW-1:0]          blend_val;
  logic                   label_in_range;

  assign label_in_range = ({1'b0, label_q} < (LW+1)'(M));

  // Blend the scanned element toward its one-hot target and clamp to [0, 1.0].
  always_comb begin
    cur_val    = snap_q[idx_q];
    target     = (idx_q == label_q) ? '1 : '0;
    diff       = $signed({1'b0, target}) - $signed({1'b0, cur_val});
    blend_step = diff >>> RATE_SHIFT;
    blend_sum  = $signed({2'b00, cur_val}) + $signed({blend_step[DW], blend_step});
    if (blend_sum[DW+1]) begin
      blend_val = '0;
    end else if (blend_sum[DW]) begin
      blend_val = '1;
    end else begin
      blend_val = blend_sum[DW-1:0];
    end
  end

  // Next-state logic: sample capture, settle countdown, argmax scan, counters.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    label_d       = label_q;
    train_d       = train_q;
    best_idx_d    = best_idx_q;
    best_val_d    = best_val_q;
    r_class_d     = r_class_q;
    r_correct_d   = r_correct_q;
    l_in_d        = l_in_q;
    snap_d        = snap_q;
    exp_d         = exp_q;
    sample_cnt_d  = sample_cnt_q;
    correct_cnt_d = correct_cnt_q;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          l_in_d  = s_in;
          label_d = s_label;
          train_d = s_train;
          cnt_d   = CNTW'(SETTLE_CYC - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          snap_d     = l_out;
          best_val_d = '0;
          best_idx_d = '0;
          idx_d      = '0;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      SCAN: begin
        if (cur_val > best_val_q) begin
          best_val_d = cur_val;
          best_idx_d = idx_q;
        end
        exp_d[idx_q] = blend_val;
        if (idx_q == LW'(M - 1)) begin
          state_d = train_q ? LEARN : REPORT;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      LEARN: begin
        state_d = REPORT;
      end
      REPORT: begin
        if (sample_cnt_q != '1) begin
          sample_cnt_d = sample_cnt_q + CW'(1);
        end
        if (r_correct_q && (correct_cnt_q != '1)) begin
          correct_cnt_d = correct_cnt_q + CW'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == REPORT) && (state_q != REPORT)) begin
      r_class_d   = best_idx_d;
      r_correct_d = (best_idx_d == label_q) && label_in_range;
    end

    if (clear_stats) begin
      sample_cnt_d  = '0;
      correct_cnt_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      label_q       <= '0;
      train_q       <= 1'b0;
      best_idx_q    <= '0;
      best_val_q    <= '0;
      r_class_q     <= '0;
      r_correct_q   <= 1'b0;
      l_in_q        <= '0;
      snap_q        <= '0;
      exp_q         <= '0;
      sample_cnt_q  <= '0;
      correct_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      label_q       <= label_d;
      train_q       <= train_d;
      best_idx_q    <= best_idx_d;
      best_val_q    <= best_val_d;
      r_class_q     <= r_class_d;
      r_correct_q   <= r_correct_d;
      l_in_q        <= l_in_d;
      snap_q        <= snap_d;
      exp_q         <= exp_d;
      sample_cnt_q  <= sample_cnt_d;
      correct_cnt_q <= correct_cnt_d;
    end
  end

  assign s_ready        = (state_q == IDLE);
  assign l_valid        = (state_q == SETTLE) && (cnt_q == CNTW'(SETTLE_CYC - 1));
  assign l_learn        = (state_q == LEARN);
  assign r_valid        = (state_q == REPORT);
  assign l_in           = l_in_q;
  assign l_expected_out = exp_q;
  assign r_class        = r_class_q;
  assign r_correct      = r_correct_q;
  assign sample_count   = sample_cnt_q;
  assign correct_count  = correct_cnt_q;

endmodule

// File: tb/tb_layer46_train_sequencer.sv
// Directed bench for the layer sequencer: reset values, inference and training
// samples, argmax ties and extremes, back-to-back handshakes, snapshot
// isolation, mid-sample reset, stats clearing and counter saturation.
module tb_layer46_train_sequencer;

  localparam int N  = 16;
  localparam int M  = 46;
  localparam int DW = 8;
  localparam int LW = 6;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              s_valid = 1'b0;
  logic [N*DW-1:0]   s_in = '0;
  logic [LW-1:0]     s_label = '0;
  logic              s_train = 1'b0;
  logic [M*DW-1:0]   l_out = '0;
  logic              clear_stats = 1'b0;

  logic              s_ready, l_valid, l_learn, r_valid, r_correct;
  logic [N*DW-1:0]   l_in;
  logic [M*DW-1:0]   l_expected_out;
  logic [LW-1:0]     r_class;
  logic [15:0]       sample_count, correct_count;

  logic              sat_s_ready, sat_l_valid, sat_l_learn, sat_r_valid, sat_r_correct;
  logic [N*DW-1:0]   sat_l_in;
  logic [M*DW-1:0]   sat_l_expected_out;
  logic [LW-1:0]     sat_r_class;
  logic [1:0]        sat_sample_count, sat_correct_count;

  int total = 0;
  int passed = 0;
  int failed = 0;

  int got_wait, got_lv_cnt, got_lv_cyc, got_learn_cnt, got_learn_cyc;
  int got_busy_ready, got_rcyc, quiet_cnt;
  logic [LW-1:0] got_class;
  logic          got_correct;
  logic [M*DW-1:0] lo, pv;

  always #5 clock = ~clock;

  layer46_train_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in), .s_label(s_label), .s_train(s_train),
    .l_in(l_in), .l_valid(l_valid), .l_learn(l_learn), .l_out(l_out),
    .l_expected_out(l_expected_out),
    .r_valid(r_valid), .r_class(r_class), .r_correct(r_correct),
    .clear_stats(clear_stats), .sample_count(sample_count), .correct_count(correct_count)
  );

  layer46_train_sequencer #(.CW(2)) dut_sat (
    .clock(clock), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(sat_s_ready), .s_in(s_in), .s_label(s_label), .s_train(s_train),
    .l_in(sat_l_in), .l_valid(sat_l_valid), .l_learn(sat_l_learn), .l_out(l_out),
    .l_expected_out(sat_l_expected_out),
    .r_valid(sat_r_valid), .r_class(sat_r_class), .r_correct(sat_r_correct),
    .clear_stats(clear_stats), .sample_count(sat_sample_count), .correct_count(sat_correct_count)
  );

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [M*DW-1:0] fill(input logic [7:0] v);
    logic [M*DW-1:0] r;
    for (int i = 0; i < M; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [M*DW-1:0] put(input logic [M*DW-1:0] v, input int i, input logic [7:0] x);
    logic [M*DW-1:0] r;
    r = v;
    r[i*DW +: DW] = x;
    return r;
  endfunction

  function automatic logic [7:0] elem(input logic [M*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Offers one sample, waits for acceptance, then follows it to its report strobe.
  task automatic apply_stimulus(input logic [LW-1:0] lab, input logic tr, input logic [N*DW-1:0] vin,
                                input logic [M*DW-1:0] lout, input logic hold,
                                input int pert_cyc, input logic [M*DW-1:0] pert_val);
    s_in = vin; s_label = lab; s_train = tr; s_valid = 1'b1; l_out = lout;
    got_wait = 0;
    while (!s_ready && got_wait < 100) begin
      step();
      got_wait++;
    end
    step();
    if (!hold) s_valid = 1'b0;
    s_in = ~vin; s_label = lab + 6'd1; s_train = ~tr;
    got_lv_cnt = 0; got_lv_cyc = -1; got_learn_cnt = 0; got_learn_cyc = -1;
    got_busy_ready = 0; got_rcyc = -1; got_class = '0; got_correct = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == pert_cyc) l_out = pert_val;
      if (l_valid) begin
        got_lv_cnt++;
        if (got_lv_cyc < 0) got_lv_cyc = cyc;
      end
      if (l_learn) begin
        got_learn_cnt++;
        if (got_learn_cyc < 0) got_learn_cyc = cyc;
      end
      if (r_valid) begin
        got_rcyc = cyc; got_class = r_class; got_correct = r_correct;
        break;
      end
      if (s_ready) got_busy_ready++;
      step();
    end
  endtask

  initial begin
    // Reset values
    #12;
    check_output("rst_s_ready", s_ready, 1);
    check_output("rst_l_valid", l_valid, 0);
    check_output("rst_l_learn", l_learn, 0);
    check_output("rst_r_valid", r_valid, 0);
    check_output("rst_r_correct", r_correct, 0);
    check_output("rst_r_class", r_class, 0);
    check_output("rst_l_in", l_in, 0);
    check_output("rst_l_exp_or", |l_expected_out, 0);
    check_output("rst_samples", sample_count, 0);
    check_output("rst_correct", correct_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Inference, label 7, l_out[7] max
    lo = put(fill(8'h10), 7, 8'hF0);
    apply_stimulus(6'd7, 1'b0, {16{8'hA5}}, lo, 1'b0, 0, '0);
    check_output("t1_lvalid_cnt", got_lv_cnt, 1);
    check_output("t1_lvalid_cyc", got_lv_cyc, 1);
    check_output("t1_rcyc", got_rcyc, 51);
    check_output("t1_class", got_class, 7);
    check_output("t1_correct", got_correct, 1);
    check_output("t1_learn_cnt", got_learn_cnt, 0);
    check_output("t1_l_in", l_in, {16{8'hA5}});
    check_output("t1_exp7", elem(l_expected_out, 7), 8'hF3);
    check_output("t1_exp0", elem(l_expected_out, 0), 8'h0C);
    step();
    check_output("t1_samples", sample_count, 1);
    check_output("t1_correct_cnt", correct_count, 1);
    check_output("t1_class_hold", r_class, 7);

    // Train, label 3, all outputs half
    apply_stimulus(6'd3, 1'b1, {16{8'h3C}}, fill(8'h80), 1'b0, 0, '0);
    check_output("t2_learn_cnt", got_learn_cnt, 1);
    check_output("t2_learn_cyc", got_learn_cyc, 51);
    check_output("t2_lvalid_cnt", got_lv_cnt, 1);
    check_output("t2_rcyc", got_rcyc, 52);
    check_output("t2_class", got_class, 0);
    check_output("t2_correct", got_correct, 0);
    check_output("t2_exp3", elem(l_expected_out, 3), 8'h9F);
    check_output("t2_exp0", elem(l_expected_out, 0), 8'h60);
    check_output("t2_exp45", elem(l_expected_out, 45), 8'h60);
    step();
    check_output("t2_samples", sample_count, 2);
    check_output("t2_correct_cnt", correct_count, 1);

    // Tie between 5 and 9 at all-ones
    lo = put(put(fill(8'h00), 5, 8'hFF), 9, 8'hFF);
    apply_stimulus(6'd5, 1'b0, {16{8'h11}}, lo, 1'b0, 0, '0);
    check_output("t3a_class", got_class, 5);
    check_output("t3a_correct", got_correct, 1);
    check_output("t3a_exp5", elem(l_expected_out, 5), 8'hFF);
    check_output("t3a_exp9", elem(l_expected_out, 9), 8'hBF);
    step();

    // Top label with all-ones output, no overflow
    lo = put(fill(8'h20), 45, 8'hFF);
    apply_stimulus(6'd45, 1'b1, {16{8'h22}}, lo, 1'b0, 0, '0);
    check_output("t3b_class", got_class, 45);
    check_output("t3b_correct", got_correct, 1);
    check_output("t3b_exp45", elem(l_expected_out, 45), 8'hFF);
    check_output("t3b_exp44", elem(l_expected_out, 44), 8'h18);
    step();
    check_output("t3b_samples", sample_count, 4);
    check_output("t3b_correct_cnt", correct_count, 3);

    // Back-to-back with s_valid held, l_out changed after snapshot
    lo = put(fill(8'h40), 2, 8'h90);
    pv = put(fill(8'h40), 30, 8'hFE);
    apply_stimulus(6'd2, 1'b0, {16{8'h5A}}, lo, 1'b1, 10, pv);
    check_output("t4a_busy_ready", got_busy_ready, 0);
    check_output("t4a_class", got_class, 2);
    check_output("t4a_correct", got_correct, 1);
    check_output("t4a_l_in", l_in, {16{8'h5A}});
    lo = put(fill(8'h33), 12, 8'h34);
    apply_stimulus(6'd12, 1'b0, {16{8'h77}}, lo, 1'b0, 0, '0);
    check_output("t4b_wait", got_wait, 1);
    check_output("t4b_rcyc", got_rcyc, 51);
    check_output("t4b_class", got_class, 12);
    check_output("t4b_l_in", l_in, {16{8'h77}});
    step();
    check_output("t4b_samples", sample_count, 6);
    check_output("t4b_correct_cnt", correct_count, 5);
    check_output("sat_samples", sat_sample_count, 3);
    check_output("sat_correct", sat_correct_count, 3);

    // Reset during SCAN
    s_in = {16{8'h99}}; s_label = 6'd4; s_train = 1'b1; s_valid = 1'b1;
    l_out = put(fill(8'h10), 4, 8'hC0);
    step();
    s_valid = 1'b0;
    repeat (20) step();
    check_output("t5_busy", s_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    check_output("t5_rst_ready", s_ready, 1);
    check_output("t5_rst_samples", sample_count, 0);
    check_output("t5_rst_correct", correct_count, 0);
    check_output("t5_rst_class", r_class, 0);
    @(negedge clock);
    reset_n = 1'b1;
    quiet_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      step();
      if (l_learn || r_valid) quiet_cnt++;
    end
    check_output("t5_quiet", quiet_cnt, 0);
    check_output("t5_idle_ready", s_ready, 1);

    // clear_stats coincident with REPORT
    apply_stimulus(6'd1, 1'b0, {16{8'h01}}, put(fill(8'h08), 1, 8'h80), 1'b0, 0, '0);
    step();
    check_output("t5_samples1", sample_count, 1);
    check_output("t5_correct1", correct_count, 1);
    apply_stimulus(6'd0, 1'b0, {16{8'h02}}, put(fill(8'h08), 0, 8'h80), 1'b0, 0, '0);
    check_output("t5_rvalid_seen", got_rcyc, 51);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check_output("t5_clr_samples", sample_count, 0);
    check_output("t5_clr_correct", correct_count, 0);

    // Out-of-range label
    lo = put(put(fill(8'h80), 10, 8'hC0), 20, 8'h04);
    apply_stimulus(6'd46, 1'b1, {16{8'hE1}}, lo, 1'b0, 0, '0);
    check_output("t6_class", got_class, 10);
    check_output("t6_correct", got_correct, 0);
    check_output("t6_learn_cnt", got_learn_cnt, 1);
    check_output("t6_exp0", elem(l_expected_out, 0), 8'h60);
    check_output("t6_exp10", elem(l_expected_out, 10), 8'h90);
    check_output("t6_exp20", elem(l_expected_out, 20), 8'h03);
    step();
    check_output("t6_samples", sample_count, 1);
    check_output("t6_correct_cnt", correct_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
